// File: rtl/ram_readout_streamer.sv
// ---------------------------------------------------------------------------
// ram_readout_streamer
//
// Reads the capture RAM word by word, from address 0 to max_ram_address-1.
// Each RAM word packs burst_index result samples of W bits, with sample 0 in
// the least-significant W bits. The block streams the samples out one at a
// time over a valid/ready port.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous active-high reset
//   start        one-cycle request to begin a full readout (IDLE or DONE only)
//   ram_addr     read address to the capture RAM
//   ram_q        RAM read data, valid ram_latency cycles after ram_addr changes
//   sample_data  one unpacked result word {cout, dout}
//   sample_valid sample_data holds a valid sample
//   sample_ready consumer accepts the sample
//   busy         readout in progress (FETCH or UNPACK)
//   done         full readout completed
//
// Handshake: a sample transfers on a rising edge where sample_valid and
// sample_ready are both 1. Once sample_valid is raised it stays high, and
// sample_data stays stable, until that transfer happens. sample_ready may
// change freely and does not affect sample_valid.
// ---------------------------------------------------------------------------
module ram_readout_streamer #(
    parameter int no_of_digits    = 8,
    parameter int radix_bits      = 3,
    parameter int address_width   = 14,
    parameter int max_ram_address = 16384,
    parameter int burst_index     = 8,
    parameter int ram_latency     = 2,
    localparam int W  = (no_of_digits + 1) * radix_bits,
    localparam int BW = W * burst_index
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [address_width-1:0] ram_addr,
    input  logic [BW-1:0]            ram_q,
    output logic [W-1:0]             sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (burst_index > 1) ? $clog2(burst_index) : 1;
    localparam int CNT_W = (ram_latency > 0) ? $clog2(ram_latency + 1) : 1;

    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(burst_index - 1);
    localparam logic [CNT_W-1:0]         LAT_CNT   = CNT_W'(ram_latency);
    localparam logic [address_width-1:0] LAST_ADDR = address_width'(max_ram_address - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UNPACK = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BW-1:0]      buffer;
    logic [IDX_W-1:0]   sample_idx;
    logic [CNT_W-1:0]   wait_cnt;

    logic xfer;
    logic last_sample;
    logic last_addr;
    logic fetch_ready;

    // sample_valid is 1 exactly in UNPACK, so it doubles as the state test.
    assign xfer        = sample_valid && sample_ready;
    assign last_sample = (sample_idx == LAST_IDX);
    assign last_addr   = (ram_addr == LAST_ADDR);
    // wait_cnt counts the ram_latency cycles plus the capture cycle.
    assign fetch_ready = (wait_cnt == LAT_CNT);

    // The buffer register itself drives the output port.
    assign sample_data = buffer[W-1:0];

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                if (fetch_ready) next_state = UNPACK;
            end
            UNPACK: begin
                if (xfer && last_sample) begin
                    next_state = last_addr ? DONE : FETCH;
                end
            end
            DONE: begin
                if (start) next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and registered status outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr     <= '0;
            buffer       <= '0;
            sample_idx   <= '0;
            wait_cnt     <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Status flags are decoded from the next state so they line up
            // with the state they describe.
            sample_valid <= (next_state == UNPACK);
            busy         <= (next_state == FETCH) || (next_state == UNPACK);
            done         <= (next_state == DONE);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ram_addr <= '0;
                        wait_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (fetch_ready) begin
                        buffer     <= ram_q;
                        sample_idx <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UNPACK: begin
                    if (xfer) begin
                        buffer     <= buffer >> W;
                        sample_idx <= sample_idx + 1'b1;
                        if (last_sample) begin
                            wait_cnt <= '0;
                            // On the final word the address holds; it never wraps.
                            if (!last_addr) ram_addr <= ram_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_readout_streamer.sv
// ---------------------------------------------------------------------------
// tb_ram_readout_streamer
//
// Small configuration: 4 RAM words of 8 samples each. Word k, sample j holds
// 8k+j in its low 8 bits. The upper 19 bits hold a tag derived from the same
// value, so every bit of the sample path is exercised.
// ---------------------------------------------------------------------------
module tb_ram_readout_streamer;

    localparam int NDIG    = 8;
    localparam int RBITS   = 3;
    localparam int AW      = 14;
    localparam int MAXADDR = 4;
    localparam int BURST   = 8;
    localparam int RAM_LAT = 2;
    localparam int W       = (NDIG + 1) * RBITS;   // 27
    localparam int BW      = W * BURST;            // 216

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [BW-1:0] ram_q;
    logic [W-1:0]  sample_data;
    logic          sample_valid;
    logic          sample_ready = 1'b1;
    logic          busy;
    logic          done;

    int vectors      = 0;
    int miscompares  = 0;
    int cyc          = 0;
    int last_xfer_cyc = 0;
    int xfer_count   = 0;

    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_readout_streamer #(
        .no_of_digits   (NDIG),
        .radix_bits     (RBITS),
        .address_width  (AW),
        .max_ram_address(MAXADDR),
        .burst_index    (BURST),
        .ram_latency    (RAM_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ram_addr    (ram_addr),
        .ram_q       (ram_q),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- RAM model ----------------
    function automatic logic [W-1:0] sample_val(int k, int j);
        logic [7:0] lo;
        lo = 8'(8 * k + j);
        return {19'h5a5a5 ^ 19'(lo), lo};
    endfunction

    // Address pipeline: ram_q reflects ram_addr RAM_LAT cycles later.
    logic [AW-1:0] addr_pipe [RAM_LAT];
    always @(posedge clk) begin
        addr_pipe[0] <= ram_addr;
        for (int i = 1; i < RAM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end

    always_comb begin
        ram_q = '0;
        for (int j = 0; j < BURST; j++) begin
            ram_q[j*W +: W] = sample_val(int'(addr_pipe[RAM_LAT-1]), j);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_samples(input int count);
        for (int n = 0; n < count; n++) exp_q.push_back(sample_val(n / BURST, n % BURST));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 once 'target' transfers have been seen.
    task automatic wait_xfers(input int target, input string name);
        int i;
        for (i = 0; i < 300 && xfer_count != target; i++) begin
            @(posedge clk); #1;
        end
        if (xfer_count != target) check({name, "_timeout"}, W'(xfer_count), W'(target));
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done"}, W'(done), W'(1));
        check({name, "_done_lat"}, W'(cyc - last_xfer_cyc), W'(1));
        check({name, "_done_busy"}, W'(busy), W'(0));
        check({name, "_done_valid"}, W'(sample_valid), W'(0));
        check({name, "_done_addr"}, W'(ram_addr), W'(MAXADDR - 1));
        check({name, "_queue_empty"}, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", sample_data, '0);
            end else begin
                exp = exp_q.pop_front();
                check("sample", sample_data, exp);
                // First sample of words 1..3: exactly RAM_LAT+1 idle cycles.
                if (exp[2:0] == 3'd0 && exp[7:0] != 8'd0)
                    check("burst_gap", W'(cyc - last_xfer_cyc - 1), W'(RAM_LAT + 1));
            end
            last_xfer_cyc = cyc;
            xfer_count++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_addr", W'(ram_addr), '0);
        check("rst_data", sample_data, '0);
        check("rst_valid", W'(sample_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);

        // Basic readout
        push_samples(MAXADDR * BURST);
        pulse_start();
        @(negedge clk);
        check("start_busy", W'(busy), W'(1));
        check("start_done", W'(done), W'(0));
        check("start_addr", W'(ram_addr), '0);
        check("start_valid", W'(sample_valid), W'(0));
        wait_done("run1");

        // Restart from DONE, with backpressure and a start pulse while busy
        base = xfer_count;
        push_samples(MAXADDR * BURST);
        pulse_start();
        @(negedge clk);
        check("restart_done", W'(done), W'(0));
        check("restart_busy", W'(busy), W'(1));
        check("restart_addr", W'(ram_addr), '0);

        wait_xfers(base + 3, "bp");
        sample_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", W'(sample_valid), W'(1));
            check("bp_data", sample_data, sample_val(0, 3));
        end
        @(posedge clk); #1;
        sample_ready = 1'b1;

        wait_xfers(base + 10, "busy_start");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_start_addr", W'(ram_addr), W'(1));
        check("busy_start_busy", W'(busy), W'(1));
        wait_done("run2");

        // Reset mid-readout at word 2, sample 5
        base = xfer_count;
        push_samples(2 * BURST + 5);
        pulse_start();
        wait_xfers(base + 2 * BURST + 5, "mid_rst");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", W'(sample_valid), '0);
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_addr", W'(ram_addr), '0);
        check("mid_rst_done", W'(done), '0);
        repeat (10) @(negedge clk);
        check("mid_rst_idle_busy", W'(busy), '0);
        check("mid_rst_queue", W'(exp_q.size()), '0);

        push_samples(MAXADDR * BURST);
        pulse_start();
        wait_done("run3");

        // Reset and start in the same cycle
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_start_busy", W'(busy), '0);
            check("rst_start_valid", W'(sample_valid), '0);
            check("rst_start_done", W'(done), '0);
            check("rst_start_addr", W'(ram_addr), '0);
        end

        check("final_queue_empty", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
